// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU function codes, RV32I opcodes and the issue entry.
// The out_illegal flag is built in only when ILLEGAL_FLAG_EN is defined.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN_DEF-1:0] op1;
    logic [XLEN_DEF-1:0] op2;
    alu_ctrl_t           ctrl;
    logic                branch;
    logic                branch_ne;
`ifdef ILLEGAL_FLAG_EN
    logic                illegal;
`endif
  } issue_entry_t;

  function automatic logic [XLEN_DEF-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN_DEF-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream (register read -> issue) and downstream (issue -> ALU) handshake bundles.
// out_illegal exists only when ILLEGAL_FLAG_EN is defined.
interface issue_in_if #(parameter int XLEN = alu_pkg::XLEN_DEF);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;

  modport master (output in_valid, in_instr, in_rs1_data, in_rs2_data, input in_ready);
  modport slave  (input in_valid, in_instr, in_rs1_data, in_rs2_data, output in_ready);
endinterface

interface alu_out_if #(parameter int XLEN = alu_pkg::XLEN_DEF);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_op1;
  logic [XLEN-1:0] alu_op2;
  logic [2:0]      alu_ctrl;
  logic            out_branch;
  logic            out_branch_ne;
`ifdef ILLEGAL_FLAG_EN
  logic            out_illegal;
`endif

  modport master (
    output out_valid, alu_op1, alu_op2, alu_ctrl, out_branch, out_branch_ne,
`ifdef ILLEGAL_FLAG_EN
    output out_illegal,
`endif
    input  out_ready
  );
  modport slave (
    input  out_valid, alu_op1, alu_op2, alu_ctrl, out_branch, out_branch_ne,
`ifdef ILLEGAL_FLAG_EN
    input  out_illegal,
`endif
    output out_ready
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode: instruction plus register data -> one issue entry.
// Undecodable instructions become add 0+0 (flagged when ILLEGAL_FLAG_EN is defined).
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_entry_t    entry
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  logic       unused_rs1_field;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  // Register numbers were consumed by the register file already.
  assign unused_rs1_field = ^instr[19:15];

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    entry     = '0;
    legal     = 1'b1;
    entry.op1 = rs1_data;
    unique case (opcode)
      OP_R: begin
        entry.op2 = rs2_data;
        unique case (f3)
          3'b000: begin
            if (f7 == 7'b0000000)      entry.ctrl = ALU_ADD;
            else if (f7 == 7'b0100000) entry.ctrl = ALU_SUB;
            else                       legal = 1'b0;
          end
          3'b010, 3'b011: entry.ctrl = ALU_SLT;
          3'b110:         entry.ctrl = ALU_OR;
          3'b111:         entry.ctrl = ALU_AND;
          default:        legal = 1'b0;
        endcase
      end
      OP_I: begin
        entry.op2 = sext12(instr[31:20]);
        unique case (f3)
          3'b000:         entry.ctrl = ALU_ADD;
          3'b010, 3'b011: entry.ctrl = ALU_SLT;
          3'b110:         entry.ctrl = ALU_OR;
          3'b111:         entry.ctrl = ALU_AND;
          default:        legal = 1'b0;
        endcase
      end
      OP_LOAD:  entry.op2 = sext12(instr[31:20]);
      OP_STORE: entry.op2 = sext12({instr[31:25], instr[11:7]});
      OP_BRANCH: begin
        if (f3[2:1] == 2'b00) begin
          entry.op2       = rs2_data;
          entry.ctrl      = ALU_SUB;
          entry.branch    = 1'b1;
          entry.branch_ne = f3[0];
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase

    if (!legal) entry = '0;
`ifdef ILLEGAL_FLAG_EN
    entry.illegal = !legal;
`endif
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: decodes into a registered output entry backed by one skid entry, so in_ready
// depends only on flopped occupancy. Optional out_illegal flag under ILLEGAL_FLAG_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN          = XLEN_DEF,
  parameter int SKID_EN_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  issue_in_if.slave in_if,
  alu_out_if.master out_if
);

  // State encoding doubles as the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [1:0] FULL_CNT = 2'(SKID_EN_DEPTH);

  state_t       state_q, state_d;
  issue_entry_t out_q, out_d;
  issue_entry_t skid_q, skid_d;
  issue_entry_t dec_entry;
  logic         in_ready;
  logic         out_valid;
  logic         accept;
  logic         drain;

  alu_issue_decode #(.XLEN(XLEN)) u_decode (
    .instr    (in_if.in_instr),
    .rs1_data (in_if.in_rs1_data),
    .rs2_data (in_if.in_rs2_data),
    .entry    (dec_entry)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: data registers are reset too, because their contents are visible on the ALU ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = dec_entry;
        end
      end
      ST_ONE: begin
        if (accept && !drain) begin
          state_d = ST_TWO;
          skid_d  = dec_entry;
        end else if (accept && drain) begin
          out_d = dec_entry;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over a same-cycle accept; a same-cycle drain has still been consumed.
    if (flush) state_d = ST_EMPTY;
  end

  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = (state_q != FULL_CNT);
    accept    = in_if.in_valid & in_ready;
    drain     = out_valid & out_if.out_ready;
  end

  assign in_if.in_ready       = in_ready;
  assign out_if.out_valid     = out_valid;
  assign out_if.alu_op1       = out_q.op1;
  assign out_if.alu_op2       = out_q.op2;
  assign out_if.alu_ctrl      = out_q.ctrl;
  assign out_if.out_branch    = out_q.branch;
  assign out_if.out_branch_ne = out_q.branch_ne;
`ifdef ILLEGAL_FLAG_EN
  assign out_if.out_illegal   = out_q.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, skid ordering, flush and mid-stream reset.
// Checks out_illegal as well when built with ILLEGAL_FLAG_EN.
module tb_alu_issue_stage;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  issue_in_if #(.XLEN(XLEN)) in_if ();
  alu_out_if  #(.XLEN(XLEN)) out_if ();

  alu_issue_stage #(.XLEN(XLEN), .SKID_EN_DEPTH(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .in_if  (in_if),
    .out_if (out_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  ctrl;
    logic        br;
    logic        ne;
    logic        ill;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  initial begin
    vecs[0]  = '{32'h002081B3, 32'd5,      32'd7,  32'd5,      32'd7,        3'b000, 1'b0, 1'b0, 1'b0}; // add
    vecs[1]  = '{32'h402081B3, 32'd9,      32'd4,  32'd9,      32'd4,        3'b001, 1'b0, 1'b0, 1'b0}; // sub
    vecs[2]  = '{32'h0020E1B3, 32'hF0,     32'h0F, 32'hF0,     32'h0F,       3'b011, 1'b0, 1'b0, 1'b0}; // or
    vecs[3]  = '{32'h0020B1B3, 32'd1,      32'd2,  32'd1,      32'd2,        3'b101, 1'b0, 1'b0, 1'b0}; // sltu
    vecs[4]  = '{32'hFFF08113, 32'd10,     32'd99, 32'd10,     32'hFFFFFFFF, 3'b000, 1'b0, 1'b0, 1'b0}; // addi -1
    vecs[5]  = '{32'h0050B113, 32'd3,      32'd0,  32'd3,      32'd5,        3'b101, 1'b0, 1'b0, 1'b0}; // sltiu 5
    vecs[6]  = '{32'h0F00F113, 32'hFF,     32'd0,  32'hFF,     32'hF0,       3'b010, 1'b0, 1'b0, 1'b0}; // andi 0xF0
    vecs[7]  = '{32'h8000A103, 32'h1000,   32'd0,  32'h1000,   32'hFFFFF800, 3'b000, 1'b0, 1'b0, 1'b0}; // lw -2048
    vecs[8]  = '{32'h7E20AFA3, 32'h20,     32'h55, 32'h20,     32'h000007FF, 3'b000, 1'b0, 1'b0, 1'b0}; // sw 0x7FF
    vecs[9]  = '{32'h00208063, 32'd3,      32'd3,  32'd3,      32'd3,        3'b001, 1'b1, 1'b0, 1'b0}; // beq
    vecs[10] = '{32'h00209063, 32'd3,      32'd3,  32'd3,      32'd3,        3'b001, 1'b1, 1'b1, 1'b0}; // bne
    vecs[11] = '{32'h0000007F, 32'h12,     32'h34, 32'd0,      32'd0,        3'b000, 1'b0, 1'b0, 1'b1}; // opcode 0x7F
    vecs[12] = '{32'h002091B3, 32'd1,      32'd2,  32'd0,      32'd0,        3'b000, 1'b0, 1'b0, 1'b1}; // sll
    vecs[13] = '{32'h0020C063, 32'd1,      32'd2,  32'd0,      32'd0,        3'b000, 1'b0, 1'b0, 1'b1}; // blt
    vecs[14] = '{32'h022081B3, 32'd1,      32'd2,  32'd0,      32'd0,        3'b000, 1'b0, 1'b0, 1'b1}; // mul
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b);
    in_if.in_valid    = v;
    in_if.in_instr    = instr;
    in_if.in_rs1_data = a;
    in_if.in_rs2_data = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    out_if.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #12;
    checks++;
    if ({out_if.out_valid, in_if.in_ready, out_if.alu_op1, out_if.alu_op2, out_if.alu_ctrl,
         out_if.out_branch, out_if.out_branch_ne} !== {1'b0, 1'b1, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got v=%b rdy=%b op1=%h op2=%h ctrl=%b br=%b ne=%b, want v=0 rdy=1 zeros",
               out_if.out_valid, in_if.in_ready, out_if.alu_op1, out_if.alu_op2, out_if.alu_ctrl,
               out_if.out_branch, out_if.out_branch_ne);
    end
`ifdef ILLEGAL_FLAG_EN
    checks++;
    if (out_if.out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal: got %b want 0", out_if.out_illegal);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_decode();
    out_if.out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      checks++;
      if ({out_if.out_valid, out_if.alu_op1, out_if.alu_op2, out_if.alu_ctrl, out_if.out_branch,
           out_if.out_branch_ne} !== {1'b1, vecs[i].op1, vecs[i].op2, vecs[i].ctrl, vecs[i].br,
           vecs[i].ne}) begin
        errors++;
        $display("FAIL decode[%0d]: got v=%b op1=%h op2=%h ctrl=%b br=%b ne=%b want v=1 op1=%h op2=%h ctrl=%b br=%b ne=%b",
                 i, out_if.out_valid, out_if.alu_op1, out_if.alu_op2, out_if.alu_ctrl,
                 out_if.out_branch, out_if.out_branch_ne, vecs[i].op1, vecs[i].op2, vecs[i].ctrl,
                 vecs[i].br, vecs[i].ne);
      end
`ifdef ILLEGAL_FLAG_EN
      checks++;
      if (out_if.out_illegal !== vecs[i].ill) begin
        errors++;
        $display("FAIL decode_illegal[%0d]: got %b want %b", i, out_if.out_illegal, vecs[i].ill);
      end
`endif
    end
    step();
    checks++;
    if (out_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL decode_drain: out_valid got %b want 0", out_if.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_if.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h11, 32'h1);
    step();
    checks++;
    if ({out_if.out_valid, in_if.in_ready, out_if.alu_op1} !== {1'b1, 1'b1, 32'h11}) begin
      errors++;
      $display("FAIL b2b_a: got v=%b rdy=%b op1=%h want 1 1 00000011",
               out_if.out_valid, in_if.in_ready, out_if.alu_op1);
    end
    drive(1'b1, 32'h002081B3, 32'h22, 32'h2);
    step();
    checks++;
    if ({out_if.out_valid, in_if.in_ready, out_if.alu_op1} !== {1'b1, 1'b0, 32'h11}) begin
      errors++;
      $display("FAIL b2b_full: got v=%b rdy=%b op1=%h want 1 0 00000011",
               out_if.out_valid, in_if.in_ready, out_if.alu_op1);
    end
    drive(1'b1, 32'h002081B3, 32'h33, 32'h3);
    step();
    checks++;
    if ({out_if.out_valid, in_if.in_ready, out_if.alu_op1, out_if.alu_op2} !==
        {1'b1, 1'b0, 32'h11, 32'h1}) begin
      errors++;
      $display("FAIL b2b_hold: got v=%b rdy=%b op1=%h op2=%h want 1 0 00000011 00000001",
               out_if.out_valid, in_if.in_ready, out_if.alu_op1, out_if.alu_op2);
    end
    out_if.out_ready = 1'b1;
    step();
    checks++;
    if ({out_if.out_valid, in_if.in_ready, out_if.alu_op1} !== {1'b1, 1'b1, 32'h22}) begin
      errors++;
      $display("FAIL b2b_b: got v=%b rdy=%b op1=%h want 1 1 00000022",
               out_if.out_valid, in_if.in_ready, out_if.alu_op1);
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    checks++;
    if ({out_if.out_valid, out_if.alu_op1, out_if.alu_op2} !== {1'b1, 32'h33, 32'h3}) begin
      errors++;
      $display("FAIL b2b_c: got v=%b op1=%h op2=%h want 1 00000033 00000003",
               out_if.out_valid, out_if.alu_op1, out_if.alu_op2);
    end
    step();
    checks++;
    if (out_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: out_valid got %b want 0", out_if.out_valid);
    end
  endtask

  task automatic test_flush();
    out_if.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'hA1, 32'h0);
    step();
    drive(1'b1, 32'h002081B3, 32'hA2, 32'h0);
    step();
    checks++;
    if (in_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_setup: in_ready got %b want 0", in_if.in_ready);
    end
    flush = 1'b1;
    drive(1'b1, 32'h002081B3, 32'hDD, 32'h0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    checks++;
    if ({out_if.out_valid, in_if.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush: got v=%b rdy=%b want v=0 rdy=1", out_if.out_valid, in_if.in_ready);
    end
    step();
    checks++;
    if (out_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: out_valid got %b want 0", out_if.out_valid);
    end
    out_if.out_ready = 1'b1;
    drive(1'b1, 32'h002081B3, 32'hEE, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    checks++;
    if ({out_if.out_valid, out_if.alu_op1} !== {1'b1, 32'hEE}) begin
      errors++;
      $display("FAIL flush_after: got v=%b op1=%h want 1 000000ee", out_if.out_valid, out_if.alu_op1);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_if.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h77, 32'h8);
    step();
    drive(1'b1, 32'h002081B3, 32'h88, 32'h9);
    checks++;
    if (out_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: out_valid got %b want 1", out_if.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_if.out_valid, in_if.in_ready, out_if.alu_op1, out_if.alu_op2} !==
        {1'b0, 1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid: got v=%b rdy=%b op1=%h op2=%h want 0 1 0 0",
               out_if.out_valid, in_if.in_ready, out_if.alu_op1, out_if.alu_op2);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (out_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: out_valid got %b want 0", out_if.out_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
